// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, data-processing cmd codes and condition codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_REG = 2'b01;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/mc_cond_unit.sv
// NZCV flag register with per-group write enables, and combinational
// condition-code evaluation against the stored flags.
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  output logic       condex
);

  logic [3:0] flags;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // flagw[1] covers N,Z; flagw[0] covers C,V. A failed condition writes nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else begin
      if (flagw[1] && condex) flags[3:2] <= aluflags[3:2];
      if (flagw[0] && condex) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle ARM controller FSM: decodes Instr and drives datapath enables/selects.
// Optional macro MC_CMP_TST_EN adds CMP/TST (flag-only) data-processing commands.
module mc_control_unit
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  logic [1:0] op;
  logic       ibit, sbit, condex, rd_pc;
  logic [3:0] cmd;
  state_t     state, next;
  logic [1:0] cmd_alu, cmd_fw, flagw;
  logic       cmd_wb;
  logic       pcw, mw, rw, irw;
  logic       unused_instr;

  assign op           = Instr[27:26];
  assign ibit         = Instr[25];
  assign cmd          = Instr[24:21];
  assign sbit         = Instr[20];
  assign rd_pc        = (Instr[15:12] == 4'd15);
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign ImmSrc = op;

  mc_cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (Instr[31:28]),
    .aluflags (ALUFlags),
    .flagw    (flagw),
    .condex   (condex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next;
  end

  // cmd_fw = {NZ, CV} write groups; cmd_wb = result goes to the register file.
  always_comb begin
    cmd_alu = ALU_ADD;
    cmd_fw  = 2'b00;
    cmd_wb  = 1'b0;
    case (cmd)
      CMD_ADD: begin cmd_alu = ALU_ADD; cmd_fw = {sbit, sbit}; cmd_wb = 1'b1; end
      CMD_SUB: begin cmd_alu = ALU_SUB; cmd_fw = {sbit, sbit}; cmd_wb = 1'b1; end
      CMD_AND: begin cmd_alu = ALU_AND; cmd_fw = {sbit, 1'b0}; cmd_wb = 1'b1; end
      CMD_ORR: begin cmd_alu = ALU_ORR; cmd_fw = {sbit, 1'b0}; cmd_wb = 1'b1; end
`ifdef MC_CMP_TST_EN
      CMD_CMP: begin cmd_alu = ALU_SUB; cmd_fw = 2'b11; end
      CMD_TST: begin cmd_alu = ALU_AND; cmd_fw = 2'b10; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   next = ibit ? S_EXECI : S_EXECR;
          OP_MEM:  next = S_MEMADR;
          OP_BR:   next = S_BRANCH;
          default: next = S_FETCH;
        endcase
      end
      S_MEMADR: next = sbit ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next = S_MEMWB;
      S_EXECR,
      S_EXECI:  next = cmd_wb ? S_ALUWB : S_FETCH;
      default:  next = S_FETCH;
    endcase
  end

  always_comb begin
    pcw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    irw        = 1'b0;
    flagw      = 2'b00;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        irw       = 1'b1;
        pcw       = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rw        = condex;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw     = condex;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_WD;
        ALUControl = cmd_alu;
        flagw      = cmd_fw;
      end
      S_ALUWB: begin
        rw  = condex;
        pcw = condex & rd_pc;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        pcw       = condex;
      end
      default: ;
    endcase
  end

  // Write strobes are held off for as long as reset is low.
  assign PCWrite  = pcw & reset;
  assign MemWrite = mw & reset;
  assign RegWrite = rw & reset;
  assign IRWrite  = irw & reset;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: a per-instruction reference model queues
// the expected control word for every cycle; a negedge monitor pops and compares.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'hE0802001;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  mc_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] v;
    logic [7:0]  ph;
    logic [31:0] id;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nmis = 0;
  int          inum = 0;
  logic [3:0]  mflags = 4'h0;
  logic [16:0] dutv;

  assign dutv = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  // phase tags used only in FAIL messages
  localparam logic [7:0] P_RST = 8'd0, P_FE = 8'd1, P_DE = 8'd2, P_MA = 8'd3,
                         P_MR = 8'd4, P_MB = 8'd5, P_MW = 8'd6, P_EX = 8'd7,
                         P_WB = 8'd8, P_BR = 8'd9, P_NOW = 8'd10;

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] expv,
                     input int ph, input int id);
    nvec++;
    if (got !== expv) begin
      nmis++;
      $display("FAIL %s phase=%0d instr#%0d got=%05h expected=%05h t=%0t",
               nm, ph, id, got, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ctl", dutv, e.v, int'(e.ph), int'(e.id));
    end
  end

  // ARM conditions come in complementary pairs: odd code = negation of the even one.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [16:0] mk(input logic [31:0] ins, input bit pcw, input bit mw,
                                     input bit rw, input bit irw, input bit adr,
                                     input logic [1:0] asa, input logic [1:0] asb,
                                     input logic [1:0] rs, input logic [1:0] alu);
    logic [1:0] rsrc;
    rsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
    return {pcw, mw, rw, irw, adr, rsrc, asa, asb, rs, ins[27:26], alu};
  endfunction

  task automatic push(input logic [16:0] v, input logic [7:0] ph);
    exp_t e;
    e.v  = v;
    e.ph = ph;
    e.id = inum;
    q.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at a window start (just after a rising edge); leaves reset released.
  task automatic do_reset(input int n);
    reset  = 1'b0;
    mflags = 4'h0;
    for (int i = 0; i < n; i++)
      push(mk(Instr, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_RST);
    hold(n);
    reset = 1'b1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [3:0] af);
    logic [1:0] op, alu;
    logic [3:0] cmd, cnd;
    bit         ce, ce2, wb, arith, logi, fl_force, sl;
    int         n;
    inum++;
    Instr    = ins;
    ALUFlags = af;
    op  = ins[27:26];
    cmd = ins[24:21];
    cnd = ins[31:28];
    sl  = ins[20];
    ce  = cond_ok(cnd, mflags);
    push(mk(ins, 1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_FE);
    push(mk(ins, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_DE);
    n = 2;
    if (op == 2'b00) begin
      alu = 2'b00; wb = 0; arith = 0; logi = 0; fl_force = 0;
      case (cmd)
        4'b0100: begin alu = 2'b00; wb = 1; arith = 1; end
        4'b0010: begin alu = 2'b01; wb = 1; arith = 1; end
        4'b0000: begin alu = 2'b10; wb = 1; logi = 1; end
        4'b1100: begin alu = 2'b11; wb = 1; logi = 1; end
`ifdef MC_CMP_TST_EN
        4'b1010: begin alu = 2'b01; arith = 1; fl_force = 1; end
        4'b1000: begin alu = 2'b10; logi = 1; fl_force = 1; end
`endif
        default: ;
      endcase
      push(mk(ins, 0, 0, 0, 0, 0, 2'b01, ins[25] ? 2'b01 : 2'b00, 2'b00, alu), P_EX);
      n++;
      if (ce && (sl || fl_force)) begin
        if (arith) mflags = af;
        if (logi)  mflags[3:2] = af[3:2];
      end
      if (wb) begin
        ce2 = cond_ok(cnd, mflags);
        push(mk(ins, ce2 && (ins[15:12] == 4'd15), 0, ce2, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), P_WB);
        n++;
      end
    end else if (op == 2'b01) begin
      push(mk(ins, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), P_MA);
      if (sl) begin
        push(mk(ins, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), P_MR);
        push(mk(ins, 0, 0, ce, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00), P_MB);
        n += 3;
      end else begin
        push(mk(ins, 0, ce, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), P_MW);
        n += 2;
      end
    end else if (op == 2'b10) begin
      push(mk(ins, ce, 0, 0, 0, 0, 2'b01, 2'b01, 2'b10, 2'b00), P_BR);
      n++;
    end
    hold(n);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [3:0]  cmds [8];
    int          r;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1000, 4'b0001, 4'b1111};
    ins = $urandom;
    ins[31:28] = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
    r = $urandom_range(0, 9);
    ins[27:26] = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    if (ins[27:26] == 2'b00) ins[24:21] = cmds[$urandom_range(0, 7)];
    if ($urandom_range(0, 5) == 0) ins[15:12] = 4'd15;
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);

    issue(32'hE0802001, 4'($urandom));  // ADD R2,R0,R1
    issue(32'hE5903004, 4'($urandom));  // LDR
    issue(32'hE5801008, 4'($urandom));  // STR
    issue(32'hE0500000, 4'b0100);       // SUBS -> Z=1
    issue(32'h0A000002, 4'($urandom));  // BEQ taken
    issue(32'h1A000002, 4'($urandom));  // BNE not taken
    issue(32'h10802001, 4'b1111);       // ADDNE skipped
    issue(32'hF0802001, 4'($urandom));  // cond 1111 ADD
    issue(32'hF5801008, 4'($urandom));  // cond 1111 STR
    issue(32'hE080F001, 4'($urandom));  // ADD PC -> PCWrite in ALUWB
    issue(32'hEC000000, 4'($urandom));  // undefined op
    issue(32'hE1500001, 4'b0110);       // CMP (flag-only when enabled, else NOP)
    issue(32'h2A000000, 4'($urandom));  // BCS observes whether CMP wrote C

    // reset during MEMRD of an LDR
    inum++;
    Instr = 32'hE5903004;
    push(mk(Instr, 1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_FE);
    push(mk(Instr, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_DE);
    push(mk(Instr, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00), P_MA);
    push(mk(Instr, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), P_MR);
    hold(3);
    #6;
    reset = 1'b0;
    #1;
    chk("reset_now", dutv, mk(Instr, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00), P_NOW, inum);
    @(posedge clk);
    #1;
    do_reset(2);
    issue(32'h0A000002, 4'($urandom));  // BEQ with cleared flags: not taken
    issue(32'h5A000002, 4'($urandom));  // BPL with cleared flags: taken

    for (int i = 0; i < 300; i++) issue(rand_instr(), 4'($urandom));

    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d expected words left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle ARM controller FSM. It is the control end of the multicycle datapath: it consumes Instr and ALUFlags and drives every datapath enable and mux select, plus MemWrite to data/instruction memory.
- Holds the NZCV flag register and evaluates condition codes.
- Sits beside the datapath inside the processor top.

Parameters:
- none; all encodings are constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- Instr  in  32  instruction register contents
- ALUFlags  in  4  {N,Z,C,V} from the current-cycle ALU result
- PCWrite  out  1  PC register enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  0 = PC, 1 = Result
- RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Instr[15:12]
- ALUSrcA  out  2  00 = PC, 01 = A
- ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24 branch
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Field names: Op = Instr[27:26], I = Instr[25], cmd = Instr[24:21], S/L = Instr[20], Rd = Instr[15:12], cond = Instr[31:28].
- Combinational decode, valid in every state:
  - RegSrc = {Op==01, Op==10}
  - ImmSrc = Op
- Moore FSM. Registered state; outputs decoded combinationally from state, Instr and CondEx.
- State outputs (any select not listed = 00, enables = 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=00, ALUSrcB=10, ResultSrc=10 (forms PC+8 for R15 reads).
  - MEMADR: ALUSrcA=01, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondEx.
  - EXECR: ALUSrcA=01, ALUSrcB=00, ALUControl from cmd.
  - EXECI: ALUSrcA=01, ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondEx; PCWrite=CondEx when Rd==15.
  - BRANCH: ALUSrcA=01, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- Transitions:
  - FETCH → DECODE
  - DECODE: Op=00 → (I ? EXECI : EXECR); Op=01 → MEMADR; Op=10 → BRANCH; Op=11 → FETCH (undefined instruction, no side effects).
  - MEMADR → (L ? MEMRD : MEMWR)
  - MEMRD → MEMWB → FETCH
  - MEMWR → FETCH
  - EXECR/EXECI → ALUWB → FETCH
  - BRANCH → FETCH
  - Illegal state encoding → FETCH.
- Latency per instruction: DP 4 cycles, LDR 5, STR 4, B 3.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other cmd is a NOP: ALUControl=ADD, EXEC → FETCH directly, no RegWrite, no flag write.
- Flags:
  - NZCV register captures ALUFlags at the end of EXECR/EXECI when S=1 and CondEx=1.
  - ADD/SUB write all four flags; AND/ORR write N,Z only.
- CondEx is combinational from cond and the stored flags:
  - Standard ARM table EQ..LE; AL (1110) = 1; 1111 = 0.
- Reset:
  - State ← FETCH and flags ← 0000 immediately on reset low.
  - While reset is low, PCWrite, MemWrite, RegWrite and IRWrite are forced 0; selects show FETCH decode.
  - Reset mid-instruction abandons it with no further writes.
  - First FETCH occurs on the first rising edge after reset goes high.

Optional Feature:
- Macro: MC_CMP_TST_EN.
- Defined:
  - cmd 1010 (CMP) uses ALUControl=SUB and writes all NZCV when CondEx, regardless of S.
  - cmd 1000 (TST) uses ALUControl=AND and writes NZ.
  - Both go EXEC → FETCH with no RegWrite.
- Undefined: 1010 and 1000 are NOPs, per the other-cmd rule above.

Decomposition:
- Package mc_pkg holds:
  - the state enum;
  - ALUControl, ALUSrcA/B, ResultSrc and ImmSrc select constants;
  - cmd and cond code constants.
- Sub-module mc_cond_unit holds the NZCV register, flag-write masking and the CondEx evaluation. The FSM lives in the top.

Test Plan:
- Reset low 2 cycles then release; Instr=0xE0802001 (ADD R2,R0,R1) → states FETCH, DECODE, EXECR, ALUWB, FETCH; IRWrite=1 only in FETCH; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
- Instr=0xE5903004 (LDR) → MEMADR (ALUSrcB=01), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); 5 cycles. Instr=0xE5801008 (STR) → RegSrc=10, MemWrite=1 only in MEMWR.
- SUBS 0xE0500000 with ALUFlags=0100 → flags Z=1. Then BEQ 0x0A000002 → BRANCH with PCWrite=1. BNE 0x1A000002 → PCWrite=0 in BRANCH, RegSrc=01.
- Z=1, ADDNE 0x10802001 → RegWrite=0 in ALUWB, flags unchanged. Instr cond=1111 → all gated writes 0.
- Assert reset during MEMRD of an LDR → PCWrite/RegWrite/IRWrite/MemWrite=0 at once, flags=0000; after release the next state is DECODE (from FETCH), with no MEMWB write.
- With MC_CMP_TST_EN: 0xE1500001 (CMP), ALUFlags=0110 → ALUControl=01, flags=0110, no ALUWB, RegWrite=0. Without the macro: flags unchanged, ALUControl=00.
